// File: rtl/pc_redirect_ctrl_if.sv
// Purpose : groups the redirect / trap handshake signals of pc_redirect_ctrl.
// Latency : n/a (wiring only).
// Backpressure: Stall freezes the PC. While a trap is pending, fetch holds until TrapAck.
//
// Port summary (slave = controller side):
//   inputs  : Stall, ExValid, RedirValid, RedirTarget[31:0], TrapAck
//   outputs : PC[PC_W-1:0], IfValid, FlushIF, FlushID, TrapReq,
//             TrapCause[1:0], TrapTarget[31:0], RedirCount[15:0]
interface pc_redirect_ctrl_if #(
    parameter int unsigned PC_W = 9
);
    logic            Stall;
    logic            ExValid;
    logic            RedirValid;
    logic [31:0]     RedirTarget;
    logic            TrapAck;

    logic [PC_W-1:0] PC;
    logic            IfValid;
    logic            FlushIF;
    logic            FlushID;
    logic            TrapReq;
    logic [1:0]      TrapCause;
    logic [31:0]     TrapTarget;
    logic [15:0]     RedirCount;

    // Controller side.
    modport slave (
        input  Stall, ExValid, RedirValid, RedirTarget, TrapAck,
        output PC, IfValid, FlushIF, FlushID, TrapReq, TrapCause,
               TrapTarget, RedirCount
    );

    // Pipeline / environment side.
    modport master (
        output Stall, ExValid, RedirValid, RedirTarget, TrapAck,
        input  PC, IfValid, FlushIF, FlushID, TrapReq, TrapCause,
               TrapTarget, RedirCount
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Purpose : fetch PC owner; applies EX-stage redirects, flushes IF/ID + ID/EX, traps bad targets.
// Latency : accept -> first valid fetch at target = FLUSH_CYCLES+1 cycles; flush is same-cycle comb.
// Backpressure: Stall holds the PC in RUN only. FLUSH/TRAP ignore redirects. TRAP holds until TrapAck.
//
// Ports:
//   clk    - core clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - pc_redirect_ctrl_if.slave (redirect inputs, PC / flush / trap outputs)
module pc_redirect_ctrl #(
    parameter int unsigned PC_W         = 9,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_redirect_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] RESET_PC_L = RESET_PC[PC_W-1:0];
    localparam logic [PC_W-1:0] TRAP_VEC_L = TRAP_VEC[PC_W-1:0];
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [3:0]      FLUSH_LD   = 4'(FLUSH_CYCLES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [3:0]      r_cnt;
    logic [1:0]      r_cause;
    logic [31:0]     r_target;
    logic [15:0]     r_redir_count;

    state_t          w_state_nxt;
    logic [PC_W-1:0] w_pc_nxt;
    logic [3:0]      w_cnt_nxt;
    logic [1:0]      w_cause_nxt;
    logic [31:0]     w_target_nxt;
    logic [15:0]     w_rcnt_nxt;

    // ------------------------------------------------------------------
    // Redirect decode
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_misaligned;
    logic w_out_of_range;
    logic w_illegal;

    // Only RUN listens to the jump/branch unit; a redirect arriving while
    // the pipe is still refilling or trapped belongs to a squashed
    // instruction and must be dropped.
    assign w_accept       = (r_state == ST_RUN) && bus.ExValid && bus.RedirValid;
    assign w_misaligned   = (bus.RedirTarget[1:0] != 2'b00);
    assign w_out_of_range = (bus.RedirTarget[31:PC_W] != '0);
    assign w_illegal      = w_misaligned || w_out_of_range;

    // ------------------------------------------------------------------
    // Next-state / next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_cnt_nxt    = r_cnt;
        w_cause_nxt  = r_cause;
        w_target_nxt = r_target;
        w_rcnt_nxt   = r_redir_count;

        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        // PC freezes on the redirecting instruction's
                        // successor; trap logic sees the bad target.
                        w_state_nxt  = ST_TRAP;
                        w_cause_nxt  = {w_out_of_range, w_misaligned};
                        w_target_nxt = bus.RedirTarget;
                    end else begin
                        // Redirect overrides Stall: the instructions the
                        // stall was protecting are being flushed anyway.
                        w_state_nxt = ST_FLUSH;
                        w_pc_nxt    = bus.RedirTarget[PC_W-1:0];
                        w_cnt_nxt   = FLUSH_LD;
                        if (r_redir_count != 16'hFFFF) begin
                            w_rcnt_nxt = r_redir_count + 16'd1;
                        end
                    end
                end else if (!bus.Stall) begin
                    w_pc_nxt = r_pc + PC_STEP;
                end
            end

            ST_FLUSH: begin
                // Counter is loaded with FLUSH_CYCLES at the accept edge,
                // so leaving on count==1 gives exactly FLUSH_CYCLES invalid
                // fetch cycles. The <= guard keeps a zero load from locking up.
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_TRAP: begin
                if (bus.TrapAck) begin
                    w_state_nxt  = ST_RUN;
                    w_pc_nxt     = TRAP_VEC_L;
                    w_cause_nxt  = 2'b00;
                    w_target_nxt = 32'h0;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC_L;
            r_cnt         <= 4'd0;
            r_cause       <= 2'b00;
            r_target      <= 32'h0;
            r_redir_count <= 16'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cause       <= w_cause_nxt;
            r_target      <= w_target_nxt;
            r_redir_count <= w_rcnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.PC         = r_pc;
    assign bus.IfValid    = (r_state == ST_RUN);
    assign bus.TrapReq    = (r_state == ST_TRAP);
    assign bus.TrapCause  = r_cause;
    assign bus.TrapTarget = r_target;
    assign bus.RedirCount = r_redir_count;

    // Both flushes fire in the accept cycle itself, legal or not, so the
    // wrong-path instructions in IF/ID and ID/EX never reach the next edge.
    assign bus.FlushIF    = w_accept;
    assign bus.FlushID    = w_accept;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Purpose : directed self-checking bench for pc_redirect_ctrl.
// Latency : n/a.
// Backpressure: n/a.
module tb_pc_redirect_ctrl;

    localparam int unsigned PC_W = 9;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    pc_redirect_ctrl_if #(.PC_W(PC_W)) bus ();

    pc_redirect_ctrl #(
        .PC_W        (PC_W),
        .RESET_PC    (32'h0),
        .TRAP_VEC    (32'h100),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ex, input logic rv, input logic [31:0] tgt,
                         input logic st, input logic ack);
        bus.ExValid     = ex;
        bus.RedirValid  = rv;
        bus.RedirTarget = tgt;
        bus.Stall       = st;
        bus.TrapAck     = ack;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();

        // ---------------- reset state ----------------
        #12;
        chk("rst_pc",      32'(bus.PC),     32'h0);
        chk("rst_cnt",     32'(bus.RedirCount), 32'h0);
        chk("rst_trapreq", 32'(bus.TrapReq), 32'h0);
        chk("rst_cause",   32'(bus.TrapCause), 32'h0);
        chk("rst_target",  bus.TrapTarget,  32'h0);
        chk("rst_flushif", 32'(bus.FlushIF), 32'h0);
        chk("rst_flushid", 32'(bus.FlushID), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- sequential fetch ----------------
        for (int i = 0; i < 5; i++) begin
            chk("seq_pc",      32'(bus.PC), 32'(4 * i));
            chk("seq_ifvalid", 32'(bus.IfValid), 32'h1);
            @(negedge clk);
        end
        // PC is 20 here; run up to 508 then wrap.
        repeat (122) @(negedge clk);
        chk("pc_508", 32'(bus.PC), 32'd508);
        @(negedge clk);
        chk("pc_wrap", 32'(bus.PC), 32'd0);
        @(negedge clk);
        chk("pc_4", 32'(bus.PC), 32'd4);

        // ---------------- stall ----------------
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc",      32'(bus.PC), 32'd4);
            chk("stall_ifvalid", 32'(bus.IfValid), 32'h1);
        end
        bus.Stall = 1'b0;
        repeat (4) @(negedge clk);
        chk("pc_20", 32'(bus.PC), 32'd20);

        // ---------------- legal redirect under stall ----------------
        drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
        #1;
        chk("acc_flushif", 32'(bus.FlushIF), 32'h1);
        chk("acc_flushid", 32'(bus.FlushID), 32'h1);
        @(negedge clk);
        chk("fl1_pc",      32'(bus.PC), 32'h40);
        chk("fl1_ifvalid", 32'(bus.IfValid), 32'h0);
        chk("fl1_cnt",     32'(bus.RedirCount), 32'h1);
        // Second redirect plus a stray TrapAck while flushing: both ignored.
        drive(1'b1, 1'b1, 32'h80, 1'b0, 1'b1);
        #1;
        chk("fl1_noflush", 32'(bus.FlushIF), 32'h0);
        @(negedge clk);
        chk("fl2_pc",      32'(bus.PC), 32'h40);
        chk("fl2_ifvalid", 32'(bus.IfValid), 32'h0);
        chk("fl2_cnt",     32'(bus.RedirCount), 32'h1);
        idle();
        @(negedge clk);
        chk("run_pc",      32'(bus.PC), 32'h40);
        chk("run_ifvalid", 32'(bus.IfValid), 32'h1);
        chk("run_trapreq", 32'(bus.TrapReq), 32'h0);
        @(negedge clk);
        chk("run_pc_inc",  32'(bus.PC), 32'h44);

        // ---------------- illegal redirect: both causes ----------------
        drive(1'b1, 1'b1, 32'h202, 1'b0, 1'b0);
        #1;
        chk("ill_flushif", 32'(bus.FlushIF), 32'h1);
        chk("ill_flushid", 32'(bus.FlushID), 32'h1);
        @(negedge clk);
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("trap_req",     32'(bus.TrapReq), 32'h1);
            chk("trap_cause",   32'(bus.TrapCause), 32'h3);
            chk("trap_target",  bus.TrapTarget, 32'h202);
            chk("trap_pc",      32'(bus.PC), 32'h44);
            chk("trap_ifvalid", 32'(bus.IfValid), 32'h0);
            if (i == 3) bus.TrapAck = 1'b1;
            @(negedge clk);
        end
        bus.TrapAck = 1'b0;
        chk("ack_pc",      32'(bus.PC), 32'h100);
        chk("ack_trapreq", 32'(bus.TrapReq), 32'h0);
        chk("ack_cause",   32'(bus.TrapCause), 32'h0);
        chk("ack_target",  bus.TrapTarget, 32'h0);
        chk("ack_cnt",     32'(bus.RedirCount), 32'h1);

        // ---------------- misaligned only ----------------
        drive(1'b1, 1'b1, 32'h42, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        chk("mis_cause", 32'(bus.TrapCause), 32'h1);
        chk("mis_pc",    32'(bus.PC), 32'h100);
        bus.TrapAck = 1'b1;
        @(negedge clk);
        bus.TrapAck = 1'b0;
        chk("mis_ack_pc", 32'(bus.PC), 32'h100);

        // ---------------- out of range only ----------------
        drive(1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        chk("oor_cause",  32'(bus.TrapCause), 32'h2);
        chk("oor_target", bus.TrapTarget, 32'h400);
        bus.TrapAck = 1'b1;
        @(negedge clk);
        bus.TrapAck = 1'b0;
        chk("oor_ack_req", 32'(bus.TrapReq), 32'h0);

        // ---------------- reset mid-flush ----------------
        drive(1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        chk("mf_ifvalid", 32'(bus.IfValid), 32'h0);
        chk("mf_cnt",     32'(bus.RedirCount), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",      32'(bus.PC), 32'h0);
        chk("arst_cnt",     32'(bus.RedirCount), 32'h0);
        chk("arst_ifvalid", 32'(bus.IfValid), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pc", 32'(bus.PC), 32'h4);

        // ---------------- saturation ----------------
        // Preload near the top rather than spending ~200k cycles counting up.
        force dut.r_redir_count = 16'hFFFD;
        #1;
        release dut.r_redir_count;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0);
            @(negedge clk);
            idle();
            chk("sat_cnt", 32'(bus.RedirCount), (i == 0) ? 32'hFFFE : 32'hFFFF);
            repeat (2) @(negedge clk);
            chk("sat_ifvalid", 32'(bus.IfValid), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
